tpu_conv_engine: RTL
====================

// Module: tpu_conv_engine
// PURPOSE
//  Parametrised successor to the byte-serial TPU core: a streaming 1-D sliding-window
//  convolution engine. It adds configurable width, tap count and output scaling,
//  signed/unsigned modes, saturation and a ready/done output handshake. It sits behind
//  the chip pin wrapper: the host loads kernel bytes, streams samples in, and pulls
//  one scaled result per accepted sample once the window is full.
// PARAMETERS
//  DATA_W  8  width of kernel coefficients, samples and results
//  TAPS    9  kernel length / window depth (>=2)
//  SHIFT   0  arithmetic right shift applied to the accumulator before saturation
//  ACC_W   2*DATA_W+$clog2(TAPS)  accumulator width (derived; do not override)
// PORTS
//  clock          in   1       single clock, rising edge
//  reset_n        in   1       asynchronous, active-low reset
//  insert_kernel  in   1       qualifies write as a kernel-coefficient write
//  write          in   1       one-cycle strobe: data_in is valid
//  write_mode     in   1       0=unsigned, 1=signed; sampled on first kernel byte
//  data_in        in   DATA_W  coefficient or sample byte
//  ready          in   1       downstream accepts data_out this cycle
//  in_ready       out  1       engine accepts a write this cycle
//  done           out  1       data_out holds a valid result
//  data_out       out  DATA_W  scaled, saturated result
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; in_ready=1; done=0; data_out=0;
//   kernel, window, kidx, fill count and accumulator = 0; mode=unsigned.
//  FSM: IDLE -> MAC (TAPS cycles) -> OUT -> IDLE. in_ready=1 only in IDLE.
//  Write accepted iff write & in_ready. Writes while in_ready=0 are dropped silently.
//  Kernel write (insert_kernel=1): kernel[kidx]<=data_in; kidx++, wraps TAPS-1 -> 0.
//   When kidx==0: latch mode<=write_mode and clear the window fill count (flush).
//   No output is produced; FSM stays in IDLE.
//  Sample write (insert_kernel=0): window shifts; the new sample enters at
//   window[TAPS-1], and window[0] is the oldest. Fill count saturates at TAPS.
//   If fill<TAPS after the shift, stay IDLE with no output.
//   Otherwise go to MAC.
//  MAC: one tap per cycle, acc += kernel[i]*window[i] for i=0..TAPS-1.
//   Operands are signed or zero-extended per mode. acc is ACC_W bits and never overflows.
//  OUT: r = acc >>> SHIFT (floor).
//   Saturate signed r to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
//   Saturate unsigned r to [0, 2^DATA_W-1].
//  Latency: sample accepted at edge t. MAC occupies cycles t+1..t+TAPS.
//   done=1 with data_out valid from cycle t+TAPS+1.
//  Handshake: done and data_out are held stable until done&ready. On that edge done<=0,
//   state<=IDLE and in_ready=1 next cycle. data_out keeps its last value after transfer.
//  The kernel may be rewritten only while IDLE. A partial kernel load is legal: unwritten
//   taps keep their old values.
//  write_mode changes outside kidx==0 writes are ignored.
//  Reset mid-MAC or mid-OUT aborts: the result is discarded, done=0 immediately.
// TESTING
//  (TAPS=3 overrides for benches; SHIFT=0 unless stated.)
//  1 Unsigned: kernel 1,2,1; samples 10,20,30 -> one done, data_out=80.
//    Then sample 40 -> data_out=120. No done after samples 10 or 20.
//  2 Saturation: unsigned kernel 1,2,1; samples 200,200,200 -> data_out=255.
//    SHIFT=2 build, samples 10,20,30 -> data_out=20.
//  3 Signed: kernel 0xFF,0x00,0x01; samples 5,3,0xFE -> data_out=0xF9 (-7).
//    Kernel 0x80,0x80,0x80 with samples 0x7F x3 -> 0x80 (-128 clamp).
//  4 Backpressure: hold ready=0 for 5 cycles after done -> data_out/done stable,
//    in_ready=0, extra writes dropped. Release ready -> one transfer, in_ready=1 next cycle.
//  5 Timing/flush: check done rises exactly TAPS+1 cycles after acceptance.
//    Reload the kernel -> next two samples give no output.
//  6 Reset: assert reset_n=0 mid-MAC -> done=0, in_ready=1, data_out=0.
//    Full reload required; a prior window yields no result.

Source files
------------

// File: rtl/tpu_conv_engine.sv
`default_nettype none
// ============================================================================
// Module      : tpu_conv_engine
// Description : Streaming 1-D sliding-window convolution engine with a
//               byte-wide kernel load path, serial MAC and a ready/done output.
// Revision    : 1.0 - initial release
// ============================================================================

module tpu_conv_engine #(
    parameter int DATA_W = 8,
    parameter int TAPS   = 9,
    parameter int SHIFT  = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              insert_kernel,
    input  logic              write,
    input  logic              write_mode,
    input  logic [DATA_W-1:0] data_in,
    input  logic              ready,
    output logic              in_ready,
    output logic              done,
    output logic [DATA_W-1:0] data_out
);

    localparam int ACC_W  = 2*DATA_W + $clog2(TAPS);
    localparam int IDX_W  = $clog2(TAPS);
    localparam int CNT_W  = $clog2(TAPS+1);
    localparam int PROD_W = 2*DATA_W;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(TAPS-1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(TAPS);
    localparam logic [CNT_W-1:0] NEAR_FULL = CNT_W'(TAPS-1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   kernel_q [TAPS];
    logic [DATA_W-1:0]   kernel_d [TAPS];
    logic [DATA_W-1:0]   window_q [TAPS];
    logic [DATA_W-1:0]   window_d [TAPS];
    logic [IDX_W-1:0]    kidx_q, kidx_d;
    logic [IDX_W-1:0]    tap_q, tap_d;
    logic [CNT_W-1:0]    fill_q, fill_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic                mode_q, mode_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   dout_q, dout_d;

    logic [DATA_W-1:0]        mac_k, mac_x;
    logic signed [PROD_W-1:0] prod_s;
    logic [PROD_W-1:0]        prod_u;
    logic [ACC_W-1:0]         prod_ext;
    logic [ACC_W-1:0]         acc_sum;
    logic signed [ACC_W-1:0]  sh_s;
    logic [ACC_W-1:0]         sh_u;
    logic [DATA_W-1:0]        sat;

    assign done     = done_q;
    assign data_out = dout_q;

    // Single shared multiplier; signed and unsigned products are kept separate
    // so that the unsigned accumulator can use its full ACC_W range.
    assign mac_k    = kernel_q[tap_q];
    assign mac_x    = window_q[tap_q];
    assign prod_s   = $signed(mac_k) * $signed(mac_x);
    assign prod_u   = mac_k * mac_x;
    assign prod_ext = mode_q ? {{(ACC_W-PROD_W){prod_s[PROD_W-1]}}, prod_s}
                             : {{(ACC_W-PROD_W){1'b0}}, prod_u};
    assign acc_sum  = acc_q + prod_ext;
    assign sh_s     = $signed(acc_sum) >>> SHIFT;
    assign sh_u     = acc_sum >> SHIFT;

    always_comb begin
        sat = '0;
        if (mode_q) begin
            if (sh_s[ACC_W-1:DATA_W-1] == {(ACC_W-DATA_W+1){sh_s[ACC_W-1]}}) begin
                sat = sh_s[DATA_W-1:0];
            end else if (sh_s[ACC_W-1]) begin
                sat = {1'b1, {(DATA_W-1){1'b0}}};
            end else begin
                sat = {1'b0, {(DATA_W-1){1'b1}}};
            end
        end else begin
            if (sh_u[ACC_W-1:DATA_W] == '0) begin
                sat = sh_u[DATA_W-1:0];
            end else begin
                sat = '1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        kernel_d = kernel_q;
        window_d = window_q;
        kidx_d   = kidx_q;
        tap_d    = tap_q;
        fill_d   = fill_q;
        acc_d    = acc_q;
        mode_d   = mode_q;
        done_d   = done_q;
        dout_d   = dout_q;
        in_ready = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (write) begin
                    if (insert_kernel) begin
                        kernel_d[kidx_q] = data_in;
                        kidx_d = (kidx_q == LAST_IDX) ? '0 : kidx_q + 1'b1;
                        // Starting a kernel load flushes the window so stale samples
                        // never meet new coefficients.
                        if (kidx_q == '0) begin
                            mode_d = write_mode;
                            fill_d = '0;
                        end
                    end else begin
                        for (int i = 0; i < TAPS-1; i++) begin
                            window_d[i] = window_q[i+1];
                        end
                        window_d[TAPS-1] = data_in;
                        if (fill_q != FULL_CNT) begin
                            fill_d = fill_q + 1'b1;
                        end
                        if (fill_q >= NEAR_FULL) begin
                            state_d = MAC;
                            tap_d   = '0;
                            acc_d   = '0;
                        end
                    end
                end
            end
            MAC: begin
                acc_d = acc_sum;
                if (tap_q == LAST_IDX) begin
                    state_d = OUT;
                    done_d  = 1'b1;
                    dout_d  = sat;
                end else begin
                    tap_d = tap_q + 1'b1;
                end
            end
            OUT: begin
                if (ready) begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            for (int i = 0; i < TAPS; i++) begin
                kernel_q[i] <= '0;
                window_q[i] <= '0;
            end
            kidx_q  <= '0;
            tap_q   <= '0;
            fill_q  <= '0;
            acc_q   <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q  <= state_d;
            kernel_q <= kernel_d;
            window_q <= window_d;
            kidx_q   <= kidx_d;
            tap_q    <= tap_d;
            fill_q   <= fill_d;
            acc_q    <= acc_d;
            mode_q   <= mode_d;
            done_q   <= done_d;
            dout_q   <= dout_d;
        end
    end

endmodule

`default_nettype wire
